// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter states, error codes and common keyboard commands.
// Imported by the line synchroniser and the host transmitter.
package ps2_pkg;

   typedef enum logic [3:0] {
      TX_IDLE,
      TX_INHIBIT,
      TX_REQ,
      TX_WAIT_FIRST,
      TX_SHIFT,
      TX_ACK,
      TX_WAIT_IDLE,
      TX_DONE,
      TX_ERR
   } ps2_tx_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_START_TO = 2'b01,
      ERR_XFER_TO  = 2'b10,
      ERR_NACK     = 2'b11
   } ps2_tx_err_t;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

   // Data held low together with clock after the inhibit period (request-to-send).
   localparam int PS2_REQ_CYC = 16;

   function automatic logic ps2_odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: two-flop synchroniser, stability filter and a registered falling-edge pulse.
// The filtered level only follows the pad after it has been steady for FILTER_LEN cycles.
module ps2_line_sync #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic line_o,
   output logic fall_o
);

   localparam int CW = $clog2(FILTER_LEN) + 1;

   logic [1:0]    sync_q;
   logic [CW-1:0] stable_cnt;

   // Idle PS/2 lines float high, so every stage resets to 1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q     <= 2'b11;
         stable_cnt <= '0;
         line_o     <= 1'b1;
         fall_o     <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], line_i};
         fall_o <= 1'b0;
         if (sync_q[1] == line_o) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
            line_o     <= sync_q[1];
            stable_cnt <= '0;
            fall_o     <= ~sync_q[1];
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one command
// byte out on device-generated clock edges and checks the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC  = 6000,
   parameter int START_TO_CYC = 750000,
   parameter int XFER_TO_CYC  = 100000,
   parameter int FILTER_LEN   = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_dat_oe_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       tx_done_o,
   output logic       tx_err_o,
   output logic [1:0] tx_err_code_o,
   output logic       rx_inhibit_o
);

   localparam int TO_MAX  = (START_TO_CYC > XFER_TO_CYC) ? START_TO_CYC : XFER_TO_CYC;
   localparam int TMR_MAX = (TO_MAX > INHIBIT_CYC) ? TO_MAX : INHIBIT_CYC;
   localparam int TW      = $clog2(TMR_MAX + 1);

   localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] REQ_LAST     = TW'(PS2_REQ_CYC - 1);
   localparam logic [TW-1:0] START_LAST   = TW'(START_TO_CYC - 1);
   localparam logic [TW-1:0] XFER_LAST    = TW'(XFER_TO_CYC - 1);

   ps2_tx_state_t state, state_n;
   ps2_tx_err_t   err_code, code_n;
   logic [TW-1:0] timer, timer_n;
   logic [3:0]    edge_cnt, edge_n;
   logic [7:0]    tx_byte, byte_n;
   logic          parity, par_n;
   logic          dat_drive, drive_n;

   logic clk_filt, clk_fall, dat_filt, dat_fall_unused;
   logic xfer_expired;

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .line_i (ps2_clk_i),
      .line_o (clk_filt),
      .fall_o (clk_fall)
   );

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .line_i (ps2_dat_i),
      .line_o (dat_filt),
      .fall_o (dat_fall_unused)
   );

   assign xfer_expired  = (timer == XFER_LAST);
   assign tx_err_code_o = (state == TX_ERR) ? err_code : ERR_NONE;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= TX_IDLE;
         err_code  <= ERR_NONE;
         timer     <= '0;
         edge_cnt  <= '0;
         tx_byte   <= '0;
         parity    <= 1'b0;
         dat_drive <= 1'b0;
      end else begin
         state     <= state_n;
         err_code  <= code_n;
         timer     <= timer_n;
         edge_cnt  <= edge_n;
         tx_byte   <= byte_n;
         parity    <= par_n;
         dat_drive <= drive_n;
      end
   end

   // One shared timer: inhibit/request hold, start timeout, then whole-transfer timeout.
   // Line drives are decoded from the state so reset releases both lines without waiting a clock.
   always_comb begin
      state_n      = state;
      code_n       = err_code;
      timer_n      = timer + 1'b1;
      edge_n       = edge_cnt;
      byte_n       = tx_byte;
      par_n        = parity;
      drive_n      = dat_drive;
      ps2_clk_oe_o = 1'b0;
      ps2_dat_oe_o = 1'b0;
      tx_ready_o   = 1'b0;
      tx_done_o    = 1'b0;
      tx_err_o     = 1'b0;
      rx_inhibit_o = 1'b1;
      case (state)
         TX_IDLE: begin
            tx_ready_o   = 1'b1;
            rx_inhibit_o = 1'b0;
            timer_n      = '0;
            if (tx_valid_i) begin
               byte_n  = tx_data_i;
               par_n   = ps2_odd_parity(tx_data_i);
               code_n  = ERR_NONE;
               state_n = TX_INHIBIT;
            end
         end
         TX_INHIBIT: begin
            ps2_clk_oe_o = 1'b1;
            if (timer == INHIBIT_LAST) begin
               timer_n = '0;
               state_n = TX_REQ;
            end
         end
         TX_REQ: begin
            ps2_clk_oe_o = 1'b1;
            ps2_dat_oe_o = 1'b1;
            if (timer == REQ_LAST) begin
               timer_n = '0;
               state_n = TX_WAIT_FIRST;
            end
         end
         TX_WAIT_FIRST: begin
            ps2_dat_oe_o = 1'b1;
            if (clk_fall) begin
               timer_n = '0;
               edge_n  = '0;
               drive_n = 1'b1;
               state_n = TX_SHIFT;
            end else if (timer == START_LAST) begin
               code_n  = ERR_START_TO;
               state_n = TX_ERR;
            end
         end
         TX_SHIFT: begin
            ps2_dat_oe_o = dat_drive;
            if (xfer_expired) begin
               code_n  = ERR_XFER_TO;
               state_n = TX_ERR;
            end else if (clk_fall) begin
               edge_n = (edge_cnt == 4'hF) ? edge_cnt : edge_cnt + 4'd1;
               if (edge_cnt < 4'd8)       drive_n = ~tx_byte[edge_cnt[2:0]];
               else if (edge_cnt == 4'd8) drive_n = ~parity;
               else                       drive_n = 1'b0;
               if (edge_cnt >= 4'd9) state_n = TX_ACK;
            end
         end
         TX_ACK: begin
            if (xfer_expired) begin
               code_n  = ERR_XFER_TO;
               state_n = TX_ERR;
            end else if (clk_fall) begin
               if (dat_filt) begin
                  code_n  = ERR_NACK;
                  state_n = TX_ERR;
               end else begin
                  state_n = TX_WAIT_IDLE;
               end
            end
         end
         TX_WAIT_IDLE: begin
            if (xfer_expired) begin
               code_n  = ERR_XFER_TO;
               state_n = TX_ERR;
            end else if (clk_filt && dat_filt) begin
               state_n = TX_DONE;
            end
         end
         TX_DONE: begin
            tx_done_o = 1'b1;
            timer_n   = '0;
            state_n   = TX_IDLE;
         end
         TX_ERR: begin
            tx_err_o = 1'b1;
            timer_n  = '0;
            state_n  = TX_IDLE;
         end
         default: begin
            state_n = TX_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a scoreboard
// monitor matches every done/err pulse against the responses queued when each request was issued.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH   = 60;
   localparam int START = 3000;
   localparam int XFER  = 2000;
   localparam int FILT  = 8;
   localparam int LAT   = 2 + FILT + 1;
   localparam int HALF  = 30;
   localparam int GAP   = 40;

   typedef struct {
      logic       is_err;
      logic [1:0] code;
      int         at_cyc;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       clk_oe, dat_oe, ready, done, err, inhibit;
   logic [1:0] code;
   logic       bus_clk, bus_dat;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   assign bus_clk = dev_clk & ~clk_oe;
   assign bus_dat = dev_dat & ~dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYC  (INH),
      .START_TO_CYC (START),
      .XFER_TO_CYC  (XFER),
      .FILTER_LEN   (FILT)
   ) dut (
      .clk_i         (clock),
      .rst_i         (rst),
      .ps2_clk_i     (bus_clk),
      .ps2_dat_i     (bus_dat),
      .ps2_clk_oe_o  (clk_oe),
      .ps2_dat_oe_o  (dat_oe),
      .tx_data_i     (tx_data),
      .tx_valid_i    (tx_valid),
      .tx_ready_o    (ready),
      .tx_done_o     (done),
      .tx_err_o      (err),
      .tx_err_code_o (code),
      .rx_inhibit_o  (inhibit)
   );

   always #10 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #4000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Scoreboard monitor: every completion pulse must match the oldest queued expectation.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (!rst && (done || err)) begin
         if (sb.size() == 0) begin
            check_output("unexpected_event", 1, 0);
         end else begin
            e = sb.pop_front();
            check_output("evt_is_err", err, e.is_err);
            check_output("evt_code", code, e.code);
            if (e.at_cyc >= 0) check_output("evt_cycle", cyc, e.at_cyc);
            check_output("evt_clk_released", clk_oe, 0);
            check_output("evt_dat_released", dat_oe, 0);
         end
      end
   end

   task automatic push_exp(input logic is_err, input logic [1:0] c, input int at);
      exp_t e;
      e.is_err = is_err;
      e.code   = c;
      e.at_cyc = at;
      sb.push_back(e);
   endtask

   task automatic apply_stimulus(input logic [7:0] data);
      @(negedge clock);
      tx_data  = data;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      check_output("accept_ready_low", ready, 0);
      check_output("accept_rx_inhibit", inhibit, 1);
   endtask

   // Device model: measures the host hold time, then generates nclk clocks sampling DAT on rises.
   task automatic device(input int nclk, input bit ack, output logic [10:0] frame,
                         output int hold, output int rel_cyc, output int fall_cyc);
      int n;
      frame    = '0;
      hold     = 0;
      rel_cyc  = -1;
      fall_cyc = -1;
      n = 0;
      while (!clk_oe && n < 100) begin
         @(negedge clock);
         n++;
      end
      while (clk_oe && hold < INH + 1000) begin
         hold++;
         @(negedge clock);
      end
      rel_cyc = cyc;
      if (nclk > 0) repeat (GAP) @(negedge clock);
      for (int i = 0; i < nclk; i++) begin
         if (i == 11 && ack) begin
            dev_dat = 1'b0;
            repeat (HALF) @(negedge clock);
         end
         dev_clk = 1'b0;
         if (i == 0) fall_cyc = cyc;
         repeat (HALF) @(negedge clock);
         dev_clk = 1'b1;
         if (i < 11) frame[i] = bus_dat;
         repeat (HALF) @(negedge clock);
      end
      dev_dat = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!ready && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_output("ready_return", ready, 1);
   endtask

   initial begin : stimulus
      logic [10:0] frame;
      int          hold, rel_cyc, fall_cyc;

      repeat (3) @(negedge clock);
      check_output("rst_clk_oe", clk_oe, 0);
      check_output("rst_dat_oe", dat_oe, 0);
      check_output("rst_ready", ready, 1);
      check_output("rst_done", done, 0);
      check_output("rst_err", err, 0);
      check_output("rst_code", code, 0);
      check_output("rst_rx_inhibit", inhibit, 0);
      rst = 1'b0;
      repeat (3) @(negedge clock);

      $display("[TB] send 0xED with ACK");
      push_exp(1'b0, 2'b00, -1);
      apply_stimulus(PS2_CMD_SET_LEDS);
      device(12, 1'b1, frame, hold, rel_cyc, fall_cyc);
      check_output("ed_frame", frame, 11'b11111011010);
      check_output("ed_clk_hold", hold, INH + 16);
      wait_idle(500);

      $display("[TB] send 0x07 and 0x00 (parity 0 and 1)");
      push_exp(1'b0, 2'b00, -1);
      apply_stimulus(8'h07);
      device(12, 1'b1, frame, hold, rel_cyc, fall_cyc);
      check_output("x07_frame", frame, 11'b10000001110);
      wait_idle(500);
      push_exp(1'b0, 2'b00, -1);
      apply_stimulus(8'h00);
      device(12, 1'b1, frame, hold, rel_cyc, fall_cyc);
      check_output("x00_frame", frame, 11'b11000000000);
      wait_idle(500);

      $display("[TB] device never clocks: start timeout");
      apply_stimulus(PS2_CMD_SET_LEDS);
      device(0, 1'b0, frame, hold, rel_cyc, fall_cyc);
      push_exp(1'b1, 2'b01, rel_cyc + START);
      wait_idle(START + 500);

      $display("[TB] device stops after 5 clocks: transfer timeout");
      apply_stimulus(8'h07);
      device(5, 1'b0, frame, hold, rel_cyc, fall_cyc);
      push_exp(1'b1, 2'b10, fall_cyc + LAT + XFER);
      wait_idle(XFER + 500);

      $display("[TB] device omits ACK: NACK");
      push_exp(1'b1, 2'b11, -1);
      apply_stimulus(PS2_CMD_SET_LEDS);
      device(12, 1'b0, frame, hold, rel_cyc, fall_cyc);
      check_output("nack_frame", frame, 11'b11111011010);
      wait_idle(500);

      $display("[TB] reset mid-transfer, then 0xFF with a busy request");
      apply_stimulus(8'h00);
      device(4, 1'b0, frame, hold, rel_cyc, fall_cyc);
      check_output("mid_dat_oe", dat_oe, 1);
      rst = 1'b1;
      #1;
      check_output("rst_mid_clk_oe", clk_oe, 0);
      check_output("rst_mid_dat_oe", dat_oe, 0);
      repeat (3) @(negedge clock);
      rst = 1'b0;
      @(negedge clock);
      check_output("post_rst_ready", ready, 1);
      check_output("post_rst_rx_inhibit", inhibit, 0);
      push_exp(1'b0, 2'b00, -1);
      apply_stimulus(PS2_CMD_RESET);
      fork
         device(12, 1'b1, frame, hold, rel_cyc, fall_cyc);
         begin
            @(negedge clock);
            tx_data  = 8'h12;
            tx_valid = 1'b1;
            @(negedge clock);
            tx_valid = 1'b0;
         end
      join
      check_output("ff_frame", frame, 11'b11111111110);
      wait_idle(500);

      repeat (50) @(negedge clock);
      check_output("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
